// File: rtl/b10_tally_pkg.sv
// Shared FSM encodings, readout selects and the vote decode helper for the
// b10 tally stage.
package b10_tally_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_COUNT = 2'd2;
    localparam state_t ST_CLEAR = 2'd3;

    localparam logic [2:0] SEL_C0    = 3'd0;
    localparam logic [2:0] SEL_C1    = 3'd1;
    localparam logic [2:0] SEL_C2    = 3'd2;
    localparam logic [2:0] SEL_C3    = 3'd3;
    localparam logic [2:0] SEL_NULL  = 3'd4;
    localparam logic [2:0] SEL_TOTAL = 3'd5;

    // Returns {valid_onehot, index[1:0]}; anything other than exactly one
    // set bit is a null ballot and returns valid_onehot=0.
    function automatic logic [2:0] vote_decode(input logic [3:0] v);
        logic [2:0] r;
        r = 3'b000;
        case (v)
            4'b0001: r = 3'b100;
            4'b0010: r = 3'b101;
            4'b0100: r = 3'b110;
            4'b1000: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/b10_vote_fifo.sv
// Small circular FIFO buffering vote words between the controller handshake
// and the tally FSM. flush outranks push and pop.
module b10_vote_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/b10_tally.sv
// Vote tally stage: buffers controller vote words, decodes each into a
// candidate or null ballot and keeps saturating tallies with a muxed readout.
//
// state | meaning
// IDLE  | waiting for a buffered word
// LOAD  | pop FIFO head into vote_q
// COUNT | update total and candidate/null tally from vote_q
// CLEAR | flush FIFO, zero tallies and sat, hold rtr low
module b10_tally
    import b10_tally_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       v_out,
    input  logic             v_valid,
    output logic             rtr,
    input  logic             clear,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             sat,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;
    logic   ready_q;
    logic   push;
    logic   pop;
    logic   flush;
    logic   fifo_full;
    logic   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [3:0] fifo_dout;
    logic [3:0] vote_q;
    logic [2:0] vote_dec;

    logic [CNT_W-1:0] cnt_cand [4];
    logic [CNT_W-1:0] cnt_null;
    logic [CNT_W-1:0] cnt_total;

    // ready_q keeps rtr low during reset and until the first edge after release.
    assign rtr   = ready_q && !fifo_full && (state != ST_CLEAR);
    assign push  = v_valid && rtr;
    assign pop   = (state == ST_LOAD) && !clear;
    assign flush = (state == ST_CLEAR);
    assign busy  = !fifo_empty || (state != ST_IDLE);

    assign vote_dec = vote_decode(vote_q);

    b10_vote_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (v_out),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // IDLE also looks at the incoming push so a lone word is counted 3 edges after accept.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clear)                      state_nxt = ST_CLEAR;
                else if (!fifo_empty || push)   state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (clear) state_nxt = ST_CLEAR;
                else       state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (clear)                  state_nxt = ST_CLEAR;
                else if (fifo_count != '0)  state_nxt = ST_LOAD;
                else                        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            vote_q  <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            if (pop) vote_q <= fifo_dout;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) cnt_cand[i] <= '0;
            cnt_null  <= '0;
            cnt_total <= '0;
            sat       <= 1'b0;
        end else if (state == ST_CLEAR) begin
            for (int i = 0; i < 4; i++) cnt_cand[i] <= '0;
            cnt_null  <= '0;
            cnt_total <= '0;
            sat       <= 1'b0;
        end else if ((state == ST_COUNT) && !clear) begin
            if (cnt_total == CNT_MAX) sat <= 1'b1;
            else                      cnt_total <= cnt_total + CNT_ONE;

            if (vote_dec[2]) begin
                if (cnt_cand[vote_dec[1:0]] == CNT_MAX) sat <= 1'b1;
                else cnt_cand[vote_dec[1:0]] <= cnt_cand[vote_dec[1:0]] + CNT_ONE;
            end else begin
                if (cnt_null == CNT_MAX) sat <= 1'b1;
                else                     cnt_null <= cnt_null + CNT_ONE;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_sel)
            SEL_C0:    rd_data = cnt_cand[0];
            SEL_C1:    rd_data = cnt_cand[1];
            SEL_C2:    rd_data = cnt_cand[2];
            SEL_C3:    rd_data = cnt_cand[3];
            SEL_NULL:  rd_data = cnt_null;
            SEL_TOTAL: rd_data = cnt_total;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_b10_tally.sv
// Self-checking bench for b10_tally: vote table, latency, backpressure,
// saturation, clear and async reset sequences against a scoreboard model.
module tb_b10_tally;
    import b10_tally_pkg::*;

    localparam int CNT_MAX = 255;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] v_out = 4'b0000;
    logic       v_valid = 1'b0;
    logic       rtr;
    logic       clear = 1'b0;
    logic [2:0] rd_sel = 3'd0;
    logic [7:0] rd_data;
    logic       sat;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int q[$];
    int mdl[6];
    int mdl_sat;

    typedef struct {
        logic [3:0] word;
        int         sel;
    } vec_t;
    vec_t vecs[8];

    b10_tally #(.DEPTH(4), .CNT_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .v_out   (v_out),
        .v_valid (v_valid),
        .rtr     (rtr),
        .clear   (clear),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .sat     (sat),
        .busy    (busy)
    );

    always #10 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 6; i++) mdl[i] = 0;
        mdl_sat = 0;
        q.delete();
    endtask

    task automatic model_update();
        int s;
        while (q.size() > 0) begin
            s = q.pop_front();
            if (mdl[s] == CNT_MAX) mdl_sat = 1; else mdl[s]++;
            if (mdl[5] == CNT_MAX) mdl_sat = 1; else mdl[5]++;
        end
    endtask

    task automatic check_all(input string tag);
        model_update();
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #1;
            check($sformatf("%s rd_sel=%0d", tag, s), int'(rd_data), (s < 6) ? mdl[s] : 0);
        end
        check($sformatf("%s sat", tag), int'(sat), mdl_sat);
    endtask

    // Called at a negedge; returns at a later negedge with v_valid low.
    task automatic send(input logic [3:0] w, input int s);
        int n;
        n = 0;
        v_out   = w;
        v_valid = 1'b1;
        while (!rtr && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rtr) check("send rtr timeout", int'(rtr), 1);
        else q.push_back(s);
        @(negedge clock);
        v_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain busy", int'(busy), 0);
    endtask

    task automatic clear_pulse();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        model_zero();
    endtask

    task automatic wait_count_state();
        int n;
        n = 0;
        while (dut.state != ST_COUNT && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("reach COUNT", int'(dut.state), int'(ST_COUNT));
    endtask

    initial begin
        int saw_low;

        vecs[0] = '{4'b0000, 4};
        vecs[1] = '{4'b0110, 4};
        vecs[2] = '{4'b1111, 4};
        vecs[3] = '{4'b0001, 0};
        vecs[4] = '{4'b0010, 1};
        vecs[5] = '{4'b1000, 3};
        vecs[6] = '{4'b1011, 4};
        vecs[7] = '{4'b0100, 2};
        model_zero();

        // reset values
        repeat (3) @(negedge clock);
        check("reset rtr", int'(rtr), 0);
        check("reset busy", int'(busy), 0);
        check_all("reset");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rtr before first edge", int'(rtr), 0);
        @(negedge clock);
        check("rtr after first edge", int'(rtr), 1);

        // single word latency: push, LOAD, COUNT
        v_out   = 4'b0100;
        v_valid = 1'b1;
        @(negedge clock);
        v_valid = 1'b0;
        q.push_back(2);
        @(negedge clock);
        rd_sel = 3'd2;
        #1;
        check("latency after 2 edges", int'(rd_data), 0);
        @(negedge clock);
        rd_sel = 3'd2;
        #1;
        check("latency after 3 edges", int'(rd_data), 1);
        check("busy after single word", int'(busy), 0);
        check_all("single");

        // table of single words
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].word, vecs[i].sel);
            drain();
            check_all($sformatf("vec%0d", i));
        end

        // backpressure with continuous offers
        clear_pulse();
        check_all("clear idle");
        saw_low = 0;
        v_out   = 4'b0001;
        v_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rtr) q.push_back(0);
            else saw_low = 1;
            @(negedge clock);
        end
        v_valid = 1'b0;
        check("backpressure rtr dropped", saw_low, 1);
        drain();
        check_all("backpressure");

        // saturation
        clear_pulse();
        for (int i = 0; i < 256; i++) send(4'b1000, 3);
        drain();
        check_all("sat 256");
        send(4'b1000, 3);
        drain();
        check_all("sat 257");

        // clear during COUNT with words buffered
        send(4'b0001, 0);
        send(4'b0010, 1);
        send(4'b0100, 2);
        wait_count_state();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("rtr in CLEAR", int'(rtr), 0);
        v_out   = 4'b0001;
        v_valid = 1'b1;
        @(negedge clock);
        v_valid = 1'b0;
        check("busy after clear", int'(busy), 0);
        model_zero();
        check_all("after clear");

        // async reset mid-COUNT
        send(4'b1000, 3);
        send(4'b0001, 0);
        wait_count_state();
        rd_sel = 3'd5;
        #3;
        reset_n = 1'b0;
        #1;
        check("async rtr", int'(rtr), 0);
        check("async busy", int'(busy), 0);
        check("async rd_data total", int'(rd_data), 0);
        model_zero();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send(4'b0010, 1);
        drain();
        check_all("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/b10_tally.md
Name: b10_tally

Overview:
- Downstream stage of the b10 voting controller.
- Consumes the 4-bit vote word (v_out) that the controller issues over its rtr handshake, and buffers words in a small FIFO.
- Decodes each word into one candidate vote or a null ballot, and keeps saturating per-candidate tallies.
- Tallies are readable through a muxed readout port for the host/display logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, range 2..16
- CNT_W, 8, width of each tally counter

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- v_out  in  4  vote word from the controller; bit i = candidate i
- v_valid  in  1  v_out is valid this cycle
- rtr  out  1  ready-to-receive to the controller
- clear  in  1  synchronous tally clear request, one-cycle pulse
- rd_sel  in  3  readout select: 0..3 = candidate 0..3, 4 = null ballots, 5 = total words, 6/7 = zero
- rd_data  out  CNT_W  selected counter, combinational from rd_sel
- sat  out  1  sticky: some counter has saturated
- busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty; all counters 0; sat=0; FSM=IDLE; busy=0.
  - rtr=0 while reset_n is low; rtr=1 from the first clock edge after release.
- Transfer:
  - A word is accepted on a rising edge where v_valid=1 and rtr=1.
  - v_valid with rtr=0 is ignored; no error is raised; the word is dropped and the controller is responsible for holding it.
- rtr = (count < DEPTH) and (state != CLEAR), combinational from registered state.
- FIFO:
  - Circular buffer with log2(DEPTH)-bit pointers that wrap from DEPTH-1 to 0, plus a count of width log2(DEPTH)+1.
  - Push and pop in the same cycle leaves count unchanged.
  - Push when full is impossible because rtr=0.
- FSM states:
  - IDLE: if clear -> CLEAR; else if FIFO non-empty -> LOAD.
  - LOAD: pop the head into vote_q. Next is COUNT; clear -> CLEAR.
  - COUNT:
    - Total counter +1.
    - If popcount(vote_q)==1, the counter for the set bit +1; otherwise (0, 2, 3 or 4 bits set) the null counter +1.
    - Next is LOAD if FIFO non-empty, else IDLE; clear -> CLEAR, and clear takes precedence over the update, so the COUNT update is discarded.
  - CLEAR: one cycle. Flush the FIFO (pointers and count to 0), zero all counters, sat=0, rtr=0, then go to IDLE.
    - A word offered during CLEAR is not accepted.
    - A word accepted in the same cycle that clear is sampled is flushed.
- Throughput: one vote per 2 cycles sustained. Latency from accept to visible tally is 3 edges (push, LOAD, COUNT) when the FIFO is empty and the FSM is idle.
- Saturation:
  - Each counter holds at 2^CNT_W-1 and does not wrap.
  - An increment attempted at max sets sat=1; sat stays set until clear or reset.
  - The total counter saturates independently.
- Simultaneous events:
  - clear outranks push, pop and count.
  - Push plus pop in LOAD is legal with a full FIFO only if rtr was 1, which is impossible when full; a push while count=DEPTH-1 during a pop succeeds.
- Reset mid-operation: everything returns to reset values immediately; partial words are lost.
- rd_data is combinational and reflects the counter value after the most recent edge.

Decomposition:
- Package b10_tally_pkg:
  - State enum (IDLE, LOAD, COUNT, CLEAR).
  - Readout select constants (SEL_C0..SEL_C3, SEL_NULL, SEL_TOTAL).
  - A popcount/one-hot-decode function returning {valid_onehot, index[1:0]}.
- Sub-module b10_vote_fifo:
  - Parameters DEPTH and width 4.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Keeps b10_tally to the FSM, counters and readout.

Test Plan:
- Reset then single word: send v_out=4'b0100 with v_valid for 1 cycle -> after 3 edges rd_sel=2 reads 1, rd_sel=5 reads 1, all others 0; busy back to 0.
- Null ballots: send 4'b0000, 4'b0110 and 4'b1111 -> null=3, total=3, candidates 0..3 = 0.
- Backpressure: DEPTH=4, drive v_valid continuously with 4'b0001 -> rtr drops when count reaches 4, and accepted words equal total. After 20 offered cycles, rd_sel=0 equals rd_sel=5, and no word is double-counted.
- Saturation: CNT_W=8, send 256 words of 4'b1000 -> candidate 3 reads 255 and sat=1; a further word leaves it at 255 while total still saturates at 255.
- Clear mid-stream: fill the FIFO with 3 words, assert clear during COUNT -> the next cycle has rtr=0, the cycle after that has all counters 0, FIFO empty, sat=0 and busy=0.
- Async reset mid-COUNT: drop reset_n between edges -> rtr, busy and rd_data go to 0 immediately without a clock; after release, new votes count from 0.
